// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction controller: ISA encodings, field positions, FSM states.
// Pure declarations; no timing or flow-control behaviour.
package cpu_pkg;

  localparam int DW = 16;
  localparam int RW = 3;

  localparam int OPC_LSB = 13;
  localparam int OPC_W   = 3;
  localparam int OP_LSB  = 11;
  localparam int OP_W    = 2;
  localparam int RN_LSB  = 8;
  localparam int RD_LSB  = 5;
  localparam int SH_LSB  = 3;
  localparam int SH_W    = 2;
  localparam int RM_LSB  = 0;
  localparam int IMM_W   = 8;

  localparam logic [OPC_W-1:0] OPC_MOV = 3'b110;
  localparam logic [OPC_W-1:0] OPC_ALU = 3'b101;

  localparam logic [OP_W-1:0] OP_MOVR = 2'b00;
  localparam logic [OP_W-1:0] OP_MOVI = 2'b10;
  localparam logic [OP_W-1:0] OP_ADD  = 2'b00;
  localparam logic [OP_W-1:0] OP_CMP  = 2'b01;
  localparam logic [OP_W-1:0] OP_AND  = 2'b10;
  localparam logic [OP_W-1:0] OP_MVN  = 2'b11;

  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_DECODE = 3'd1,
    ST_WR_IMM = 3'd2,
    ST_GET_A  = 3'd3,
    ST_GET_B  = 3'd4,
    ST_ALU    = 3'd5,
    ST_WR_REG = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    IC_MOVI, IC_MOVR, IC_ADD, IC_CMP, IC_AND, IC_MVN, IC_ILLEGAL
  } iclass_e;

  function automatic iclass_e classify(input logic [OPC_W-1:0] opc, input logic [OP_W-1:0] op);
    iclass_e c;
    c = IC_ILLEGAL;
    if (opc == OPC_MOV) begin
      if (op == OP_MOVI) c = IC_MOVI;
      else if (op == OP_MOVR) c = IC_MOVR;
    end else if (opc == OPC_ALU) begin
      case (op)
        OP_ADD:  c = IC_ADD;
        OP_CMP:  c = IC_CMP;
        OP_AND:  c = IC_AND;
        default: c = IC_MVN;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/cpu_if.sv
// Host handshake plus datapath strobe bundle; master is the controller side.
// No storage, no latency; the host only offers load/s while w is high.
interface cpu_if;
  import cpu_pkg::*;

  logic          load;
  logic [DW-1:0] instr;
  logic          s;
  logic          w;
  logic          err;
  logic [RW-1:0] readnum;
  logic [RW-1:0] writenum;
  logic          write;
  logic          vsel;
  logic          loada;
  logic          loadb;
  logic          loadc;
  logic          loads;
  logic          asel;
  logic          bsel;
  logic [1:0]    shift;
  logic [1:0]    ALUop;
  logic [DW-1:0] datapath_in;

  modport master (
    input  load, instr, s,
    output w, err, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
           asel, bsel, shift, ALUop, datapath_in
  );

  modport slave (
    output load, instr, s,
    input  w, err, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
           asel, bsel, shift, ALUop, datapath_in
  );

endinterface

// File: rtl/cpu_instr_decoder.sv
// Combinational split of the instruction register into fields and an instruction class.
// Zero latency; no flow control.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [DW-1:0]   ir,
  output logic [RW-1:0]   rn,
  output logic [RW-1:0]   rd,
  output logic [RW-1:0]   rm,
  output logic [SH_W-1:0] sh,
  output logic [OP_W-1:0] op,
  output logic [DW-1:0]   sximm8,
  output iclass_e         iclass
);

  assign rn     = ir[RN_LSB +: RW];
  assign rd     = ir[RD_LSB +: RW];
  assign rm     = ir[RM_LSB +: RW];
  assign sh     = ir[SH_LSB +: SH_W];
  assign op     = ir[OP_LSB +: OP_W];
  assign sximm8 = {{(DW-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
  assign iclass = classify(ir[OPC_LSB +: OPC_W], ir[OP_LSB +: OP_W]);

endmodule

// File: rtl/cpu_controller.sv
// Instruction register plus Moore FSM sequencing the register-file/ALU strobes.
// 2-6 edges per instruction from s; load/s are only honoured while w is high.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  cpu_if.master  bus
);

  logic [DW-1:0]   ir_q, ir_d;
  state_e          state_q, state_d;
  logic [RW-1:0]   rn, rd, rm;
  logic [SH_W-1:0] sh;
  logic [OP_W-1:0] op;
  logic [DW-1:0]   sximm8;
  iclass_e         iclass;

  instr_decoder u_dec (
    .ir     (ir_q),
    .rn     (rn),
    .rd     (rd),
    .rm     (rm),
    .sh     (sh),
    .op     (op),
    .sximm8 (sximm8),
    .iclass (iclass)
  );

  // IR is frozen for the whole instruction; only WAIT accepts a new word.
  always_comb begin
    ir_d = ir_q;
    if (state_q == ST_WAIT && bus.load) ir_d = bus.instr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  assign bus.datapath_in = sximm8;

  always_comb begin
    state_d      = state_q;
    bus.w        = 1'b0;
    bus.err      = 1'b0;
    bus.readnum  = '0;
    bus.writenum = '0;
    bus.write    = 1'b0;
    bus.vsel     = 1'b0;
    bus.loada    = 1'b0;
    bus.loadb    = 1'b0;
    bus.loadc    = 1'b0;
    bus.loads    = 1'b0;
    bus.asel     = 1'b0;
    bus.bsel     = 1'b0;
    bus.shift    = '0;
    bus.ALUop    = '0;
    case (state_q)
      ST_WAIT: begin
        bus.w = 1'b1;
        if (bus.s) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        case (iclass)
          IC_MOVI:              state_d = ST_WR_IMM;
          IC_ADD, IC_CMP, IC_AND: state_d = ST_GET_A;
          IC_MOVR, IC_MVN:      state_d = ST_GET_B;
          default: begin
            bus.err = 1'b1;
            state_d = ST_WAIT;
          end
        endcase
      end
      ST_WR_IMM: begin
        bus.writenum = rn;
        bus.vsel     = 1'b1;
        bus.write    = 1'b1;
        state_d      = ST_WAIT;
      end
      ST_GET_A: begin
        bus.readnum = rn;
        bus.loada   = 1'b1;
        state_d     = ST_GET_B;
      end
      ST_GET_B: begin
        bus.readnum = rm;
        bus.loadb   = 1'b1;
        state_d     = ST_ALU;
      end
      ST_ALU: begin
        bus.shift = sh;
        // MOV reg rides the ADD path with A forced to zero.
        bus.asel  = (iclass == IC_MOVR) || (iclass == IC_MVN);
        bus.ALUop = (iclass == IC_MOVR) ? 2'b00 : op;
        if (iclass == IC_CMP) begin
          bus.loads = 1'b1;
          state_d   = ST_WAIT;
        end else begin
          bus.loadc = 1'b1;
          state_d   = ST_WR_REG;
        end
      end
      ST_WR_REG: begin
        bus.writenum = rd;
        bus.write    = 1'b1;
        state_d      = ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase
  end

endmodule
